// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch-stage controller and the decode logic that feeds it.
// Target helpers live here so decode-side models compute redirects identically.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fsm_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // Word offset scaled to bytes; modular add, overflow is not flagged.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] off);
    return pc_plus4 + {{14{off[15]}}, off, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: picks the next PC, drives PC/IR write enables, squashes
// wrong-path fetches after a redirect, holds on load-use stalls and freezes on halt.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FLUSH_SLOTS = 1,
  parameter logic [31:0] NOP_WORD    = fetch_sequencer_pkg::NOP_WORD,
  parameter int          CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      pc_plus4,
  input  logic             branch_req,
  input  logic [15:0]      branch_off,
  input  logic             jump_req,
  input  logic [25:0]      jump_index,
  input  logic             stall_req,
  input  logic             halt_req,
  input  logic             resume,
  output logic [31:0]      pc_next,
  output logic             pc_we,
  output logic             ir_we,
  output logic             ir_sel_nop,
  output logic             halted,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // The squash word must itself decode as harmless, or a flushed slot would redirect or halt.
  if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > 3) begin : g_bad_flush_slots
    $error("fetch_sequencer: FLUSH_SLOTS must be 1..3");
  end
  if (NOP_WORD[31:26] == OP_BEQ || NOP_WORD[31:26] == OP_J ||
      NOP_WORD[31:26] == OP_HALT) begin : g_bad_nop_word
    $error("fetch_sequencer: NOP_WORD decodes as a control instruction");
  end

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_SLOTS - 1);

  fsm_state_e state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       redirect_inc;
  logic       stall_inc;

  always_ff @(posedge CLK) begin
    state_q     <= state_d;
    flush_cnt_q <= flush_cnt_d;
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    pc_next      = pc_plus4;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    ir_sel_nop   = 1'b0;
    halted       = 1'b0;
    redirect_inc = 1'b0;
    stall_inc    = 1'b0;

    if (RESET) begin
      state_d     = ST_RUN;
      flush_cnt_d = '0;
      pc_next     = RESET_PC;
      pc_we       = 1'b1;
      ir_we       = 1'b1;
      ir_sel_nop  = 1'b1;
    end else begin
      case (state_q)
        // STALL re-evaluates like RUN the moment stall_req drops.
        ST_RUN, ST_STALL: begin
          if (stall_req) begin
            stall_inc = 1'b1;
            state_d   = ST_STALL;
          end else if (jump_req || branch_req) begin
            pc_next      = jump_req ? jump_target(pc_plus4, jump_index)
                                    : branch_target(pc_plus4, branch_off);
            pc_we        = 1'b1;
            ir_we        = 1'b1;
            ir_sel_nop   = 1'b1;
            redirect_inc = 1'b1;
            if (FLUSH_SLOTS == 1) begin
              state_d = ST_RUN;
            end else begin
              flush_cnt_d = FLUSH_LOAD;
              state_d     = ST_FLUSH;
            end
          end else if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            pc_we   = 1'b1;
            ir_we   = 1'b1;
            state_d = ST_RUN;
          end
        end
        // Requests seen here belong to squashed instructions and are dropped.
        ST_FLUSH: begin
          pc_we      = 1'b1;
          ir_we      = 1'b1;
          ir_sel_nop = 1'b1;
          if (flush_cnt_q != 2'd0) begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
          if (flush_cnt_q <= 2'd1) begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          if (resume) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign fsm_state = state_q;

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .CLK     (CLK),
    .clr_i   (RESET),
    .inc_i   (redirect_inc),
    .count_o (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .clr_i   (RESET),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: one instance with a single squash slot, one with three slots and narrow counters.
module tb_fetch_sequencer;

  logic        CLK;
  logic        RESET;
  logic [31:0] pc_plus4;
  logic        branch_req;
  logic [15:0] branch_off;
  logic        jump_req;
  logic [25:0] jump_index;
  logic        stall_req;
  logic        halt_req;
  logic        resume;

  logic [31:0] pc_next_a, pc_next_b;
  logic        pc_we_a, pc_we_b, ir_we_a, ir_we_b;
  logic        nop_a, nop_b, halted_a, halted_b;
  logic [1:0]  state_a, state_b;
  logic [15:0] rcnt_a, scnt_a;
  logic [2:0]  rcnt_b, scnt_b;

  logic [31:0] pc_q;
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  fetch_sequencer #(.FLUSH_SLOTS(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RESET(RESET), .pc_plus4(pc_plus4),
    .branch_req(branch_req), .branch_off(branch_off),
    .jump_req(jump_req), .jump_index(jump_index),
    .stall_req(stall_req), .halt_req(halt_req), .resume(resume),
    .pc_next(pc_next_a), .pc_we(pc_we_a), .ir_we(ir_we_a), .ir_sel_nop(nop_a),
    .halted(halted_a), .fsm_state(state_a),
    .redirect_cnt(rcnt_a), .stall_cnt(scnt_a)
  );

  fetch_sequencer #(.FLUSH_SLOTS(3), .CNT_W(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .pc_plus4(pc_plus4),
    .branch_req(branch_req), .branch_off(branch_off),
    .jump_req(jump_req), .jump_index(jump_index),
    .stall_req(stall_req), .halt_req(halt_req), .resume(resume),
    .pc_next(pc_next_b), .pc_we(pc_we_b), .ir_we(ir_we_b), .ir_sel_nop(nop_b),
    .halted(halted_b), .fsm_state(state_b),
    .redirect_cnt(rcnt_b), .stall_cnt(scnt_b)
  );

  // Clock/reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // PC register of the fetch datapath, loaded from instance A.
  always_ff @(posedge CLK) begin
    if (pc_we_a) pc_q <= pc_next_a;
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    branch_req = 1'b0;
    jump_req   = 1'b0;
    stall_req  = 1'b0;
    halt_req   = 1'b0;
    resume     = 1'b0;
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    idle();
    branch_off = 16'h0000;
    jump_index = 26'h0;
    pc_plus4   = 32'h0;
    RESET      = 1'b1;
    #2;
    check("rst_pc_next", pc_next_a, 32'h0);
    check("rst_pc_we", pc_we_a, 1);
    check("rst_ir_we", ir_we_a, 1);
    check("rst_nop", nop_a, 1);
    tick();
    tick();
    RESET = 1'b0;
    check("rst_state", state_a, 0);
    check("rst_rcnt", rcnt_a, 0);
    check("rst_scnt", scnt_a, 0);
    check("rst_halted", halted_a, 0);

    // Sequential fetch
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      pc_plus4 = pc_q + 32'd4;
      #1;
      check("seq_pc", pc_q, e);
      check("seq_pc_next", pc_next_a, e + 32'd4);
      check("seq_pc_we", pc_we_a, 1);
      check("seq_nop", nop_a, 0);
      tick();
    end
    check("seq_pc_end", pc_q, 32'h10);

    // Forward and backward branch
    pc_plus4 = 32'h40; branch_req = 1'b1; branch_off = 16'h0004;
    #1;
    check("br_fwd_target", pc_next_a, 32'h50);
    check("br_fwd_nop", nop_a, 1);
    check("br_fwd_we", pc_we_a, 1);
    tick();
    branch_req = 1'b0; pc_plus4 = 32'h54;
    #1;
    check("br_fwd_rcnt", rcnt_a, 1);
    check("br_fwd_state", state_a, 0);
    check("br_after_nop", nop_a, 0);
    check("br_after_pc", pc_next_a, 32'h54);
    tick();
    pc_plus4 = 32'h40; branch_req = 1'b1; branch_off = 16'hFFFF;
    #1;
    check("br_back_target", pc_next_a, 32'h3C);
    tick();
    branch_req = 1'b0;
    check("br_back_rcnt", rcnt_a, 2);

    // Jump beats branch; upper PC bits come from pc_plus4
    pc_plus4 = 32'h5C; jump_req = 1'b1; branch_req = 1'b1; branch_off = 16'h0004;
    jump_index = 26'd5;
    #1;
    check("jmp_target", pc_next_a, 32'h14);
    check("jmp_nop", nop_a, 1);
    tick();
    check("jmp_rcnt", rcnt_a, 3);
    pc_plus4 = 32'hA000_0100; branch_req = 1'b0; jump_index = 26'h3FF_FFFF;
    #1;
    check("jmp_region", pc_next_a, 32'hAFFF_FFFC);
    tick();
    jump_req = 1'b0;
    check("jmp_rcnt2", rcnt_a, 4);

    // Stall beats a pending branch for three cycles
    pc_plus4 = 32'h40; branch_req = 1'b1; branch_off = 16'h0004; stall_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_pc_we", pc_we_a, 0);
      check("stall_ir_we", ir_we_a, 0);
      tick();
    end
    check("stall_cnt3", scnt_a, 3);
    check("stall_state", state_a, 1);
    stall_req = 1'b0;
    #1;
    check("stall_exit_pc", pc_next_a, 32'h50);
    check("stall_exit_we", pc_we_a, 1);
    check("stall_exit_nop", nop_a, 1);
    tick();
    branch_req = 1'b0;
    check("stall_exit_state", state_a, 0);
    check("stall_exit_rcnt", rcnt_a, 5);
    check("stall_cnt_hold", scnt_a, 3);

    // Three-slot squash on instance B
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst2_rcnt", rcnt_a, 0);
    check("rst2_scnt", scnt_a, 0);
    pc_plus4 = 32'h40; branch_req = 1'b1; branch_off = 16'h0004;
    #1;
    check("fl_target", pc_next_b, 32'h50);
    check("fl_nop0", nop_b, 1);
    tick();
    check("fl_state1", state_b, 2);
    pc_plus4 = 32'h54;
    #1;
    check("fl_ignore_br", pc_next_b, 32'h54);
    check("fl_nop1", nop_b, 1);
    check("fl_we1", ir_we_b, 1);
    tick();
    branch_req = 1'b0; pc_plus4 = 32'h58;
    check("fl_state2", state_b, 2);
    #1;
    check("fl_nop2", nop_b, 1);
    tick();
    pc_plus4 = 32'h5C;
    check("fl_state_run", state_b, 0);
    #1;
    check("fl_nop_done", nop_b, 0);
    check("fl_seq_pc", pc_next_b, 32'h5C);
    check("fl_rcnt", rcnt_b, 1);
    check("a_rcnt_during_fl", rcnt_a, 2);
    tick();

    // Halt: PC frozen, requests ignored, resume restarts sequential fetch
    pc_plus4 = 32'h80;
    tick();
    check("pre_halt_pc", pc_q, 32'h80);
    pc_plus4 = 32'h84; halt_req = 1'b1;
    #1;
    check("halt_entry_we", pc_we_a, 0);
    tick();
    halt_req = 1'b0;
    check("halt_state", state_a, 3);
    for (int i = 0; i < 10; i++) begin
      branch_req = i[0];
      stall_req  = i[1];
      jump_req   = i[2];
      #1;
      check("halt_halted", halted_a, 1);
      check("halt_pc_we", pc_we_a, 0);
      tick();
      check("halt_pc_frozen", pc_q, 32'h80);
    end
    idle();
    check("halt_rcnt", rcnt_a, 2);
    check("halt_scnt", scnt_a, 0);
    resume = 1'b1;
    #1;
    check("resume_cycle_we", pc_we_a, 0);
    tick();
    resume = 1'b0;
    #1;
    check("resume_state", state_a, 0);
    check("resume_halted", halted_a, 0);
    check("resume_pc_next", pc_next_a, 32'h84);
    check("resume_nop", nop_a, 0);
    tick();
    check("resume_pc", pc_q, 32'h84);

    // Reset during HALT
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt2_state", state_a, 3);
    RESET = 1'b1;
    #1;
    check("rst_in_halt_halted", halted_a, 0);
    check("rst_in_halt_pc", pc_next_a, 32'h0);
    check("rst_in_halt_we", pc_we_a, 1);
    tick();
    RESET = 1'b0;
    check("rst_in_halt_state", state_a, 0);
    check("rst_in_halt_rcnt", rcnt_a, 0);

    // Counter saturation on the 3-bit instance
    stall_req = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    stall_req = 1'b0;
    check("sat_b", scnt_b, 7);
    check("nosat_a", scnt_a, 9);
    check("sat_state", state_a, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller for the fetch stage (PC register, PC+4 adder, instruction memory, IR).
- Each cycle it selects the next PC (sequential, branch target or jump target) and drives PC and IR write enables.
- Squashes wrong-path instructions after a redirect, holds fetch on load-use stalls, and freezes fetch on halt.
- Sits between decode/hazard logic and the fetch datapath; all outputs feed the PC and IR registers directly.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded while RESET is high.
- FLUSH_SLOTS, 1, number of IR loads squashed after a redirect; legal range 1..3.
- NOP_WORD, 32'h00000000, word loaded into IR when squashing.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- pc_plus4  in  32  PC+4 from the fetch adder.
- branch_req  in  1  taken beq resolved in decode this cycle.
- branch_off  in  16  beq immediate, in words.
- jump_req  in  1  j decoded this cycle.
- jump_index  in  26  j target field, in words.
- stall_req  in  1  load-use hazard on the decode instruction.
- halt_req  in  1  decode holds a halt instruction.
- resume  in  1  leave HALT.
- pc_next  out  32  value for the PC register.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- ir_sel_nop  out  1  IR loads NOP_WORD instead of memory data.
- halted  out  1  FSM in HALT.
- fsm_state  out  2  RUN=0, STALL=1, FLUSH=2, HALT=3.
- redirect_cnt  out  CNT_W  saturating count of accepted redirects.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: state RUN, flush counter 0, both counters 0, halted 0.
- During the RESET cycle: pc_next=RESET_PC, pc_we=1, ir_we=1, ir_sel_nop=1.
- Control outputs are combinational from state and inputs; state and counters are registered. Decisions take effect at the next posedge with zero added latency.
- Branch target: pc_plus4 + (sign_extend(branch_off) << 2), 32-bit modular add; wrap-around is not detected.
- Jump target: {pc_plus4[31:28], jump_index, 2'b00}.
- Priority each cycle: RESET > HALT > stall > jump > branch > sequential. Jump wins when jump_req and branch_req are both high.
- RUN, sequential: pc_next=pc_plus4, pc_we=1, ir_we=1, ir_sel_nop=0.
- RUN, stall_req: pc_we=0, ir_we=0, stall_cnt++, go to STALL.
  - Stall beats a same-cycle redirect; the redirect is re-presented by decode once the stall clears.
- RUN, redirect: pc_next=target, pc_we=1, ir_we=1, ir_sel_nop=1 (squashes the wrong-path fetch), redirect_cnt++.
  - If FLUSH_SLOTS==1, stay in RUN; otherwise load the flush counter with FLUSH_SLOTS-1 and go to FLUSH.
- RUN, halt_req (no stall, no redirect): pc_we=0, ir_we=0, go to HALT.
- STALL: pc_we=0, ir_we=0, stall_cnt++ while stall_req stays high.
  - When stall_req drops, evaluate exactly as RUN in that same cycle and move to RUN (or to FLUSH/HALT per that evaluation).
- FLUSH: pc_next=pc_plus4, pc_we=1, ir_we=1, ir_sel_nop=1, counter decrements; return to RUN when the counter reaches 0.
  - branch_req, jump_req, stall_req and halt_req are ignored here, because they come from squashed instructions.
- HALT: pc_we=0, ir_we=0, halted=1.
  - resume returns to RUN on the next edge; the next fetch is sequential from the held PC.
  - While halted, all request inputs other than resume are ignored.
- Counters saturate at all-ones and never wrap. RESET clears them.
- RESET asserted mid-STALL, mid-FLUSH or mid-HALT aborts immediately and returns to RUN.

Decomposition:
- Shared package holds: state encoding (RUN/STALL/FLUSH/HALT), NOP_WORD, and opcode constants for beq (6'h04), j (6'h02) and halt (6'h3F), for use by the decode logic driving this block.
- One natural sub-module: sat_counter (parameterised width, inc and clr inputs), instantiated twice.

Test Plan:
- RESET high 2 cycles, then low, pc_plus4 driven from a PC model → pc_next=0 during reset; afterwards pc_we=1 and PC steps 0, 4, 8, C.
- pc_plus4=0x40, branch_req=1, branch_off=0x0004 → pc_next=0x50, ir_sel_nop=1 for one load, redirect_cnt=1. Repeat with branch_off=0xFFFF → pc_next=0x3C.
- pc_plus4=0x5C, jump_req=1 and branch_req=1 together, jump_index=5 → pc_next=0x14 (jump wins), redirect_cnt increments by 1.
- stall_req high 3 cycles with branch_req high → pc_we=0 and ir_we=0 for 3 cycles, stall_cnt=3. On the 4th cycle the branch is taken.
- FLUSH_SLOTS=3, redirect → ir_sel_nop high for 3 consecutive IR loads; a branch_req pulse during FLUSH is ignored; FSM returns to RUN.
- halt_req → halted=1 and PC frozen for 10 cycles; resume → sequential fetch restarts; RESET asserted during HALT → RUN, counters 0.
